// File: rtl/sisc_mc.sv
// sisc_mc: parametrised multi-cycle SISC core with req/ack instruction and data ports.
// Execution is strictly sequential; HALT is left only through reset.
module sisc_mc #(
    parameter int DW   = 32,
    parameter int AW   = 16,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [AW-1:0] pc_out,
    output logic [3:0]    stat_out,
    output logic          halted,
    output logic          retire
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] OP_ALU_R = 4'h1;
    localparam logic [3:0] OP_ALU_I = 4'h2;
    localparam logic [3:0] OP_LOD   = 4'h3;
    localparam logic [3:0] OP_STR   = 4'h4;
    localparam logic [3:0] OP_BRA   = 4'h5;
    localparam logic [3:0] OP_HLT   = 4'hF;

    // state    | meaning
    // S_FETCH  | imem request outstanding, wait for ack
    // S_DECODE | read operands into A/B
    // S_EXEC   | ALU/branch/halt complete; loads/stores latch address
    // S_MEM    | dmem request outstanding, wait for ack
    // S_HALT   | stopped until reset
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [3:0]    stat_q, stat_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    logic [3:0]    opcode, mm, rd, rs, rt;
    logic [DW-1:0] imm_ext, opnd, alu_res, wr_data;
    logic [DW:0]   sum;
    logic          alu_ok, alu_c, alu_v, wr_en;

    assign opcode  = ir_q[31:28];
    assign mm      = ir_q[27:24];
    assign rd      = ir_q[23:20];
    assign rs      = ir_q[19:16];
    assign rt      = ir_q[15:12];
    assign imm_ext = DW'(ir_q[15:0]);
    assign opnd    = (opcode == OP_ALU_I) ? imm_ext : b_q;

    function automatic logic [DW-1:0] reg_read(input logic [3:0] idx);
        return (idx != 4'd0 && int'(idx) < NREG) ? regs_q[idx[IW-1:0]] : '0;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            stat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            stat_q  <= stat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_LOD || opcode == OP_STR) state_d = S_MEM;
                else if (opcode == OP_HLT)                state_d = S_HALT;
                else                                      state_d = S_FETCH;
            end
            S_MEM:    if (dmem_ack) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_ok  = 1'b1;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = '0;
        case (mm)
            4'd0: begin
                sum     = {1'b0, a_q} + {1'b0, opnd};
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
                alu_v   = (a_q[DW-1] == opnd[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            4'd1: begin
                // borrow lands in the extra bit; carry flag is its inverse
                sum     = {1'b0, a_q} - {1'b0, opnd};
                alu_res = sum[DW-1:0];
                alu_c   = ~sum[DW];
                alu_v   = (a_q[DW-1] != opnd[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            4'd2:    alu_res = a_q & opnd;
            4'd3:    alu_res = a_q | opnd;
            4'd4:    alu_res = a_q ^ opnd;
            default: alu_ok  = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        stat_d  = stat_q;
        a_d     = a_q;
        b_d     = b_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_en   = 1'b0;
        wr_data = alu_res;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d = imem_rdata;
                    pc_d = pc_q + AW'(1);
                end
            end
            S_DECODE: begin
                a_d = reg_read(rs);
                b_d = (opcode == OP_STR) ? reg_read(rd) : reg_read(rt);
            end
            S_EXEC: begin
                case (opcode)
                    OP_ALU_R, OP_ALU_I: begin
                        if (alu_ok) begin
                            wr_en  = 1'b1;
                            stat_d = {alu_c, alu_res[DW-1], alu_res == '0, alu_v};
                        end
                    end
                    OP_BRA: begin
                        if (mm == 4'd0 || (stat_q & mm) != 4'd0) pc_d = imm_ext[AW-1:0];
                    end
                    OP_LOD, OP_STR: begin
                        addr_d  = a_q[AW-1:0] + imm_ext[AW-1:0];
                        wdata_d = b_q;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack && opcode == OP_LOD) begin
                    wr_en   = 1'b1;
                    wr_data = dmem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en && rd != 4'd0 && int'(rd) < NREG) regs_d[rd[IW-1:0]] = wr_data;
    end

    // Outputs are forced idle while rst_f is low so no request leaks during reset.
    always_comb begin
        imem_req   = rst_f && (state_q == S_FETCH);
        imem_addr  = pc_q;
        dmem_req   = rst_f && (state_q == S_MEM);
        dmem_we    = dmem_req && (opcode == OP_STR);
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        pc_out     = pc_q;
        stat_out   = stat_q;
        halted     = rst_f && (state_q == S_HALT);
        retire     = rst_f && (((state_q == S_EXEC) && opcode != OP_LOD && opcode != OP_STR)
                               || ((state_q == S_MEM) && dmem_ack));
    end
endmodule
